axis_pkt_arbiter: RTL and testbench

- Packet-level round-robin arbiter that shares the single AXI-Stream write path into the HMAC/SHA-1 input FIFO between NUM_REQ message sources (e.g. key-pad generator, message loader, outer-hash feeder).
- Grants one requester at a time and locks the grant until that requester's tlast beat is accepted.
- Reports the granted source and the length of each forwarded packet to the HMAC top-level sequencer.

---
 rtl/hmac_pkg.sv | 13 +
 rtl/axis_pkt_arbiter_rr_pick.sv | 26 ++
 rtl/axis_pkt_arbiter.sv | 111 +++++++++++
 tb/tb_axis_pkt_arbiter.sv | 393 +++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/hmac_pkg.sv
// Shared definitions for the HMAC/SHA-1 input-side stream logic.
package hmac_pkg;

  // Arbiter FSM: IDLE waits for a request, LOCK forwards one whole packet.
  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_LOCK = 1'b1
  } state_t;

  // Default stream width of the FIFO write path.
  localparam int AXIS_WIDTH = 32;

endpackage

// File: rtl/axis_pkt_arbiter_rr_pick.sv
// Combinational round-robin picker: returns the first asserted request found
// when searching upward from (last+1) mod NUM_REQ, wrapping around.
module rr_pick #(
  parameter int NUM_REQ = 2
) (
  input  logic [NUM_REQ-1:0] req,
  input  logic [1:0]         last,
  output logic [1:0]         idx,
  output logic               any
);

  // Scan offsets 1..NUM_REQ so the previous winner is considered last.
  always_comb begin
    idx = '0;
    any = 1'b0;
    for (int off = 1; off <= NUM_REQ; off++) begin
      for (int k = 0; k < NUM_REQ; k++) begin
        if (!any && req[k] && (((int'(last) + off) % NUM_REQ) == k)) begin
          idx = 2'(k);
          any = 1'b1;
        end
      end
    end
  end

endmodule

// File: rtl/axis_pkt_arbiter.sv
// Packet-level round-robin arbiter sharing one AXI-Stream write path between
// NUM_REQ sources. The grant is held from the first beat until the granted
// source's tlast beat is accepted, then one bubble cycle precedes the next
// grant. Each completed packet is reported with its source and beat count.
module axis_pkt_arbiter
  import hmac_pkg::*;
#(
  parameter int WIDTH   = AXIS_WIDTH,
  parameter int NUM_REQ = 2,
  parameter int CNT_W   = 16
) (
  input  logic                     i_clk,
  input  logic                     i_rst,
  input  logic [NUM_REQ-1:0]       tvalid_s,
  input  logic [NUM_REQ*WIDTH-1:0] tdata_s,
  input  logic [NUM_REQ-1:0]       tlast_s,
  output logic [NUM_REQ-1:0]       tready_s,
  output logic                     tvalid_m,
  output logic [WIDTH-1:0]         tdata_m,
  output logic                     tlast_m,
  input  logic                     tready_m,
  output logic [1:0]               o_grant_id,
  output logic                     o_busy,
  output logic                     o_pkt_done,
  output logic [CNT_W-1:0]         o_pkt_len
);

  state_t           state;
  logic [1:0]       grant;
  logic [1:0]       last_grant;
  logic [CNT_W-1:0] beat_cnt;
  logic [1:0]       pick_idx;
  logic             pick_any;
  logic             hs;

  // Beat counter increment that sticks at all-ones instead of wrapping.
  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (v == {CNT_W{1'b1}}) ? v : v + 1'b1;
  endfunction

  rr_pick #(
    .NUM_REQ(NUM_REQ)
  ) u_pick (
    .req  (tvalid_s),
    .last (last_grant),
    .idx  (pick_idx),
    .any  (pick_any)
  );

  // Zero-latency path from the granted source to the FIFO; everything is
  // forced low while idle so no source sees a ready before it is granted.
  always_comb begin
    tvalid_m = 1'b0;
    tdata_m  = '0;
    tlast_m  = 1'b0;
    tready_s = '0;
    if (state == ST_LOCK) begin
      for (int k = 0; k < NUM_REQ; k++) begin
        if (grant == 2'(k)) begin
          tvalid_m    = tvalid_s[k];
          tdata_m     = tdata_s[k*WIDTH +: WIDTH];
          tlast_m     = tlast_s[k];
          tready_s[k] = tready_m;
        end
      end
    end
  end

  assign hs = tvalid_m & tready_m;

  // Grant FSM, beat counter and packet completion report.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state      <= ST_IDLE;
      grant      <= '0;
      last_grant <= 2'(NUM_REQ - 1);
      beat_cnt   <= '0;
      o_grant_id <= '0;
      o_busy     <= 1'b0;
      o_pkt_done <= 1'b0;
      o_pkt_len  <= '0;
    end else begin
      o_pkt_done <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (pick_any) begin
            grant      <= pick_idx;
            o_grant_id <= pick_idx;
            o_busy     <= 1'b1;
            state      <= ST_LOCK;
          end
        end
        ST_LOCK: begin
          if (hs) begin
            if (tlast_m) begin
              o_pkt_done <= 1'b1;
              o_pkt_len  <= sat_inc(beat_cnt);
              last_grant <= grant;
              beat_cnt   <= '0;
              o_busy     <= 1'b0;
              state      <= ST_IDLE;
            end else begin
              beat_cnt <= sat_inc(beat_cnt);
            end
          end
        end
      endcase
    end
  end

endmodule

// File: tb/tb_axis_pkt_arbiter.sv
// Bench for axis_pkt_arbiter: per-source packet queues drive the requesters,
// a queue-based round-robin model predicts the forwarded beat stream and the
// packet reports, and each scenario task compares what it observed.
module tb_axis_pkt_arbiter;

  localparam int W  = 32;
  localparam int NR = 2;
  localparam int CW = 16;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic              rst;
  logic [NR-1:0]     tvalid_s, tlast_s, tready_s, tready_s2;
  logic [NR*W-1:0]   tdata_s;
  logic              tvalid_m, tlast_m, tready_m, busy, done;
  logic [W-1:0]      tdata_m;
  logic [1:0]        gid;
  logic [CW-1:0]     plen;
  logic              tvalid_m2, tlast_m2, busy2, done2;
  logic [W-1:0]      tdata_m2;
  logic [1:0]        gid2;
  logic [1:0]        plen2;

  axis_pkt_arbiter #(.WIDTH(W), .NUM_REQ(NR), .CNT_W(CW)) dut (
    .i_clk(clk), .i_rst(rst), .tvalid_s(tvalid_s), .tdata_s(tdata_s),
    .tlast_s(tlast_s), .tready_s(tready_s), .tvalid_m(tvalid_m),
    .tdata_m(tdata_m), .tlast_m(tlast_m), .tready_m(tready_m),
    .o_grant_id(gid), .o_busy(busy), .o_pkt_done(done), .o_pkt_len(plen)
  );

  // Narrow-counter copy fed the same inputs, used to observe saturation.
  axis_pkt_arbiter #(.WIDTH(W), .NUM_REQ(NR), .CNT_W(2)) dut_sat (
    .i_clk(clk), .i_rst(rst), .tvalid_s(tvalid_s), .tdata_s(tdata_s),
    .tlast_s(tlast_s), .tready_s(tready_s2), .tvalid_m(tvalid_m2),
    .tdata_m(tdata_m2), .tlast_m(tlast_m2), .tready_m(tready_m),
    .o_grant_id(gid2), .o_busy(busy2), .o_pkt_done(done2), .o_pkt_len(plen2)
  );

  typedef struct packed { logic [W-1:0] data; logic last; } beat_t;
  typedef struct packed { logic [W-1:0] data; logic last; logic [1:0] gid; } obs_t;
  typedef struct packed { logic [CW-1:0] len; logic [1:0] gid; } pkt_t;

  beat_t       src_q[NR][$];
  obs_t        fwd_q[$], exp_fwd_q[$];
  pkt_t        done_q[$], exp_done_q[$];
  logic [1:0]  done2_q[$];
  logic [W-1:0] stall_q[$];
  bit          rdy_pat[$];

  int n_checks = 0;
  int n_pass   = 0;
  int model_last = NR - 1;
  int first_v, first_m;
  int gap_force[NR];
  bit gap_watch = 1'b0;
  int gap_bad, gap_seen;
  bit rdy0_seen;
  bit to;

  // Passive monitor of the FIFO side and the packet reports.
  always @(negedge clk) begin
    if (tvalid_m && tready_m) fwd_q.push_back('{data: tdata_m, last: tlast_m, gid: gid});
    if (done) done_q.push_back('{len: plen, gid: gid});
    if (done2) done2_q.push_back(plen2);
  end

  initial begin
    #500000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  task automatic clear_all();
    for (int k = 0; k < NR; k++) begin src_q[k].delete(); gap_force[k] = 0; end
    fwd_q.delete(); exp_fwd_q.delete(); done_q.delete(); exp_done_q.delete();
    done2_q.delete(); stall_q.delete(); rdy_pat.delete();
  endtask

  task automatic add_pkt(input int k, input int len, input logic [W-1:0] base, input bit rnd);
    for (int i = 0; i < len; i++)
      src_q[k].push_back('{data: rnd ? W'($urandom) : base + W'(i + 1), last: (i == len - 1)});
  endtask

  // Reference: whole packets granted round-robin among sources with work left.
  task automatic build_expect();
    beat_t pk[NR][$];
    int cur, len;
    bit any;
    for (int k = 0; k < NR; k++) pk[k] = src_q[k];
    while (1) begin
      any = 1'b0;
      cur = 0;
      for (int off = 1; off <= NR; off++) begin
        if (!any && pk[(model_last + off) % NR].size() > 0) begin
          cur = (model_last + off) % NR;
          any = 1'b1;
        end
      end
      if (!any) break;
      len = 0;
      while (pk[cur].size() > 0) begin
        beat_t b;
        b = pk[cur].pop_front();
        len++;
        exp_fwd_q.push_back('{data: b.data, last: b.last, gid: 2'(cur)});
        if (b.last) break;
      end
      exp_done_q.push_back('{len: CW'(len), gid: 2'(cur)});
      model_last = cur;
    end
  endtask

  task automatic do_reset();
    rst = 1'b1; tvalid_s = '0; tlast_s = '0; tready_m = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    clear_all();
    model_last = NR - 1;
  endtask

  // Drives the source queues cycle by cycle until drained (plus a few cycles
  // for the completion pulse), or until stop_beats handshakes have happened.
  task automatic run(input int budget, input bit gaps, input bit rand_rdy,
                     input int stop_beats, output bit timed_out);
    int  extra, cyc, nbeats;
    bit  started[NR];
    bit  all_empty;
    logic v;
    extra = 0; cyc = 0; nbeats = 0;
    first_v = -1; first_m = -1; gap_bad = 0; gap_seen = 0; rdy0_seen = 1'b0;
    for (int k = 0; k < NR; k++) started[k] = 1'b0;
    timed_out = 1'b1;
    while (cyc < budget) begin
      all_empty = 1'b1;
      for (int k = 0; k < NR; k++) if (src_q[k].size() > 0) all_empty = 1'b0;
      if (all_empty && stop_beats == 0) begin
        extra++;
        if (extra > 3) begin timed_out = 1'b0; break; end
      end
      for (int k = 0; k < NR; k++) begin
        if (src_q[k].size() > 0) begin
          v = 1'b1;
          if (started[k] && gaps && $urandom_range(0, 3) == 0) v = 1'b0;
          if (started[k] && gap_force[k] > 0) begin v = 1'b0; gap_force[k]--; end
          tvalid_s[k] = v;
          tdata_s[k*W +: W] = src_q[k][0].data;
          tlast_s[k] = src_q[k][0].last;
        end else begin
          tvalid_s[k] = 1'b0;
          tdata_s[k*W +: W] = W'($urandom);
          tlast_s[k] = 1'($urandom_range(0, 1));
        end
      end
      if (rdy_pat.size() > 0) tready_m = rdy_pat.pop_front();
      else if (rand_rdy) tready_m = 1'($urandom_range(0, 1));
      else tready_m = 1'b1;
      if (tvalid_s != '0 && first_v < 0) first_v = cyc;
      @(negedge clk);
      if (tvalid_m && first_m < 0) first_m = cyc;
      if (tvalid_m && !tready_m) stall_q.push_back(tdata_m);
      if (tready_s[0]) rdy0_seen = 1'b1;
      if (gap_watch && started[0] && !tvalid_s[0] && src_q[0].size() > 0) begin
        gap_seen++;
        if (!busy || gid !== 2'd0) gap_bad++;
      end
      for (int k = 0; k < NR; k++) begin
        if (tvalid_s[k] && tready_s[k]) begin
          started[k] = !src_q[k][0].last;
          void'(src_q[k].pop_front());
          nbeats++;
        end
      end
      @(posedge clk); #1;
      cyc++;
      if (stop_beats > 0 && nbeats >= stop_beats) begin timed_out = 1'b0; break; end
    end
  endtask

  task automatic test_reset();
    rst = 1'b1; tvalid_s = '1; tdata_s = {$urandom, $urandom}; tlast_s = '1; tready_m = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    @(negedge clk);
    n_checks++; if (tvalid_m !== 1'b0) $display("FAIL reset_tvalid_m got %b exp 0", tvalid_m); else n_pass++;
    n_checks++; if (tready_s !== '0) $display("FAIL reset_tready_s got %b exp 0", tready_s); else n_pass++;
    n_checks++; if (tdata_m !== '0) $display("FAIL reset_tdata_m got %h exp 0", tdata_m); else n_pass++;
    n_checks++; if (tlast_m !== 1'b0) $display("FAIL reset_tlast_m got %b exp 0", tlast_m); else n_pass++;
    n_checks++; if (busy !== 1'b0) $display("FAIL reset_busy got %b exp 0", busy); else n_pass++;
    n_checks++; if (done !== 1'b0) $display("FAIL reset_done got %b exp 0", done); else n_pass++;
    n_checks++; if (plen !== '0) $display("FAIL reset_len got %0d exp 0", plen); else n_pass++;
    n_checks++; if (gid !== 2'd0) $display("FAIL reset_grant got %0d exp 0", gid); else n_pass++;
    rst = 1'b0; tvalid_s = '0;
    @(posedge clk); #1;
    clear_all();
    model_last = NR - 1;
  endtask

  task automatic test_single();
    clear_all();
    add_pkt(0, 3, '0, 1'b0);
    build_expect();
    run(100, 1'b0, 1'b0, 0, to);
    n_checks++; if (to) $display("FAIL single_timeout got 1 exp 0"); else n_pass++;
    n_checks++; if (first_m - first_v !== 1) $display("FAIL single_latency got %0d exp 1", first_m - first_v); else n_pass++;
    n_checks++; if (fwd_q.size() !== exp_fwd_q.size()) $display("FAIL single_nbeats got %0d exp %0d", fwd_q.size(), exp_fwd_q.size()); else n_pass++;
    for (int i = 0; i < fwd_q.size() && i < exp_fwd_q.size(); i++) begin
      n_checks++;
      if (fwd_q[i] !== exp_fwd_q[i]) $display("FAIL single_beat%0d got %h/%b/%0d exp %h/%b/%0d", i, fwd_q[i].data, fwd_q[i].last, fwd_q[i].gid, exp_fwd_q[i].data, exp_fwd_q[i].last, exp_fwd_q[i].gid); else n_pass++;
    end
    n_checks++; if (done_q.size() !== exp_done_q.size()) $display("FAIL single_npkts got %0d exp %0d", done_q.size(), exp_done_q.size()); else n_pass++;
    for (int i = 0; i < done_q.size() && i < exp_done_q.size(); i++) begin
      n_checks++;
      if (done_q[i] !== exp_done_q[i]) $display("FAIL single_pkt%0d got len %0d id %0d exp len %0d id %0d", i, done_q[i].len, done_q[i].gid, exp_done_q[i].len, exp_done_q[i].gid); else n_pass++;
    end
    @(negedge clk);
    n_checks++; if (plen !== CW'(3)) $display("FAIL single_len_held got %0d exp 3", plen); else n_pass++;
    n_checks++; if (done !== 1'b0) $display("FAIL single_done_width got %b exp 0", done); else n_pass++;
    @(posedge clk); #1;
  endtask

  task automatic test_contention();
    clear_all();
    add_pkt(0, 2, 32'h10, 1'b0);
    add_pkt(1, 2, 32'h20, 1'b0);
    build_expect();
    run(100, 1'b0, 1'b0, 0, to);
    n_checks++; if (to) $display("FAIL contention_timeout got 1 exp 0"); else n_pass++;
    n_checks++; if (fwd_q.size() !== exp_fwd_q.size()) $display("FAIL contention_nbeats got %0d exp %0d", fwd_q.size(), exp_fwd_q.size()); else n_pass++;
    for (int i = 0; i < fwd_q.size() && i < exp_fwd_q.size(); i++) begin
      n_checks++;
      if (fwd_q[i] !== exp_fwd_q[i]) $display("FAIL contention_beat%0d got %h/%b/%0d exp %h/%b/%0d", i, fwd_q[i].data, fwd_q[i].last, fwd_q[i].gid, exp_fwd_q[i].data, exp_fwd_q[i].last, exp_fwd_q[i].gid); else n_pass++;
    end
    n_checks++; if (done_q.size() !== exp_done_q.size()) $display("FAIL contention_npkts got %0d exp %0d", done_q.size(), exp_done_q.size()); else n_pass++;
    for (int i = 0; i < done_q.size() && i < exp_done_q.size(); i++) begin
      n_checks++;
      if (done_q[i] !== exp_done_q[i]) $display("FAIL contention_pkt%0d got len %0d id %0d exp len %0d id %0d", i, done_q[i].len, done_q[i].gid, exp_done_q[i].len, exp_done_q[i].gid); else n_pass++;
    end
  endtask

  task automatic test_fairness();
    clear_all();
    for (int p = 0; p < 4; p++)
      for (int k = 0; k < NR; k++) add_pkt(k, 1, 32'h100 * (k + 1) + 32'(p * 16), 1'b0);
    build_expect();
    run(200, 1'b0, 1'b0, 0, to);
    n_checks++; if (to) $display("FAIL fair_timeout got 1 exp 0"); else n_pass++;
    n_checks++; if (done_q.size() !== exp_done_q.size()) $display("FAIL fair_npkts got %0d exp %0d", done_q.size(), exp_done_q.size()); else n_pass++;
    for (int i = 0; i < done_q.size() && i < exp_done_q.size(); i++) begin
      n_checks++;
      if (done_q[i] !== exp_done_q[i]) $display("FAIL fair_pkt%0d got len %0d id %0d exp len %0d id %0d", i, done_q[i].len, done_q[i].gid, exp_done_q[i].len, exp_done_q[i].gid); else n_pass++;
    end
    for (int i = 1; i < done_q.size(); i++) begin
      n_checks++;
      if (done_q[i].gid === done_q[i-1].gid) $display("FAIL fair_repeat%0d got id %0d twice exp alternating", i, done_q[i].gid); else n_pass++;
    end
    n_checks++; if (fwd_q.size() !== exp_fwd_q.size()) $display("FAIL fair_nbeats got %0d exp %0d", fwd_q.size(), exp_fwd_q.size()); else n_pass++;
    for (int i = 0; i < fwd_q.size() && i < exp_fwd_q.size(); i++) begin
      n_checks++;
      if (fwd_q[i] !== exp_fwd_q[i]) $display("FAIL fair_beat%0d got %h/%0d exp %h/%0d", i, fwd_q[i].data, fwd_q[i].gid, exp_fwd_q[i].data, exp_fwd_q[i].gid); else n_pass++;
    end
  endtask

  task automatic test_backpressure();
    clear_all();
    model_last = 0;
    do_reset();
    model_last = 0;
    // one-beat req0 packet moves the round-robin pointer onto req1
    add_pkt(0, 1, 32'h2F, 1'b0);
    build_expect();
    run(50, 1'b0, 1'b0, 0, to);
    clear_all();
    add_pkt(1, 3, 32'h30, 1'b0);
    rdy_pat = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1};
    build_expect();
    run(100, 1'b0, 1'b0, 0, to);
    n_checks++; if (to) $display("FAIL bp_timeout got 1 exp 0"); else n_pass++;
    n_checks++; if (stall_q.size() !== 2) $display("FAIL bp_nstall got %0d exp 2", stall_q.size()); else n_pass++;
    for (int i = 0; i < stall_q.size(); i++) begin
      n_checks++;
      if (stall_q[i] !== exp_fwd_q[1].data) $display("FAIL bp_held%0d got %h exp %h", i, stall_q[i], exp_fwd_q[1].data); else n_pass++;
    end
    n_checks++; if (rdy0_seen !== 1'b0) $display("FAIL bp_tready0 got %b exp 0", rdy0_seen); else n_pass++;
    n_checks++; if (fwd_q.size() !== exp_fwd_q.size()) $display("FAIL bp_nbeats got %0d exp %0d", fwd_q.size(), exp_fwd_q.size()); else n_pass++;
    for (int i = 0; i < fwd_q.size() && i < exp_fwd_q.size(); i++) begin
      n_checks++;
      if (fwd_q[i] !== exp_fwd_q[i]) $display("FAIL bp_beat%0d got %h/%b/%0d exp %h/%b/%0d", i, fwd_q[i].data, fwd_q[i].last, fwd_q[i].gid, exp_fwd_q[i].data, exp_fwd_q[i].last, exp_fwd_q[i].gid); else n_pass++;
    end
    n_checks++; if (done_q.size() !== 1 || done_q[0] !== exp_done_q[0]) $display("FAIL bp_pkt got %0d pkts exp len %0d id %0d", done_q.size(), exp_done_q[0].len, exp_done_q[0].gid); else n_pass++;
  endtask

  task automatic test_gap();
    clear_all();
    add_pkt(0, 3, 32'h40, 1'b0);
    add_pkt(1, 2, 32'h50, 1'b0);
    gap_force[0] = 4;
    gap_watch = 1'b1;
    build_expect();
    run(100, 1'b0, 1'b0, 0, to);
    gap_watch = 1'b0;
    n_checks++; if (to) $display("FAIL gap_timeout got 1 exp 0"); else n_pass++;
    n_checks++; if (gap_seen !== 4) $display("FAIL gap_cycles got %0d exp 4", gap_seen); else n_pass++;
    n_checks++; if (gap_bad !== 0) $display("FAIL gap_lock got %0d bad cycles exp 0", gap_bad); else n_pass++;
    n_checks++; if (fwd_q.size() !== exp_fwd_q.size()) $display("FAIL gap_nbeats got %0d exp %0d", fwd_q.size(), exp_fwd_q.size()); else n_pass++;
    for (int i = 0; i < fwd_q.size() && i < exp_fwd_q.size(); i++) begin
      n_checks++;
      if (fwd_q[i] !== exp_fwd_q[i]) $display("FAIL gap_beat%0d got %h/%b/%0d exp %h/%b/%0d", i, fwd_q[i].data, fwd_q[i].last, fwd_q[i].gid, exp_fwd_q[i].data, exp_fwd_q[i].last, exp_fwd_q[i].gid); else n_pass++;
    end
  endtask

  task automatic test_saturation();
    do_reset();
    add_pkt(0, 5, 32'h60, 1'b0);
    build_expect();
    run(100, 1'b0, 1'b0, 0, to);
    n_checks++; if (to) $display("FAIL sat_timeout got 1 exp 0"); else n_pass++;
    n_checks++; if (done_q.size() !== 1 || done_q[0].len !== CW'(5)) $display("FAIL sat_wide_len got %0d pkts exp one of len 5", done_q.size()); else n_pass++;
    n_checks++; if (done2_q.size() !== 1 || done2_q[0] !== 2'd3) $display("FAIL sat_narrow_len got %0d pkts exp one of len 3", done2_q.size()); else n_pass++;
  endtask

  task automatic test_reset_mid();
    do_reset();
    add_pkt(0, 1, 32'h70, 1'b0);
    add_pkt(1, 5, 32'h80, 1'b0);
    build_expect();
    run(100, 1'b0, 1'b0, 3, to);
    n_checks++; if (to) $display("FAIL rmid_timeout got 1 exp 0"); else n_pass++;
    rst = 1'b1;
    @(posedge clk); #1;
    @(negedge clk);
    n_checks++; if (tvalid_m !== 1'b0) $display("FAIL rmid_tvalid_m got %b exp 0", tvalid_m); else n_pass++;
    n_checks++; if (tready_s !== '0) $display("FAIL rmid_tready_s got %b exp 0", tready_s); else n_pass++;
    n_checks++; if (tdata_m !== '0) $display("FAIL rmid_tdata_m got %h exp 0", tdata_m); else n_pass++;
    n_checks++; if (busy !== 1'b0) $display("FAIL rmid_busy got %b exp 0", busy); else n_pass++;
    n_checks++; if (gid !== 2'd0) $display("FAIL rmid_grant got %0d exp 0", gid); else n_pass++;
    n_checks++; if (plen !== '0) $display("FAIL rmid_len got %0d exp 0", plen); else n_pass++;
    n_checks++; if (done_q.size() !== 1) $display("FAIL rmid_no_done got %0d pkts exp 1", done_q.size()); else n_pass++;
    rst = 1'b0; tvalid_s = '0;
    @(posedge clk); #1;
    clear_all();
    model_last = NR - 1;
    add_pkt(1, 1, 32'hA0, 1'b0);
    add_pkt(0, 1, 32'h90, 1'b0);
    build_expect();
    run(100, 1'b0, 1'b0, 0, to);
    n_checks++; if (to) $display("FAIL rmid_post_timeout got 1 exp 0"); else n_pass++;
    n_checks++; if (done_q.size() !== exp_done_q.size()) $display("FAIL rmid_post_npkts got %0d exp %0d", done_q.size(), exp_done_q.size()); else n_pass++;
    for (int i = 0; i < done_q.size() && i < exp_done_q.size(); i++) begin
      n_checks++;
      if (done_q[i] !== exp_done_q[i]) $display("FAIL rmid_post_pkt%0d got len %0d id %0d exp len %0d id %0d", i, done_q[i].len, done_q[i].gid, exp_done_q[i].len, exp_done_q[i].gid); else n_pass++;
    end
  endtask

  task automatic test_random();
    for (int r = 0; r < 6; r++) begin
      clear_all();
      for (int k = 0; k < NR; k++)
        for (int p = $urandom_range(0, 3); p > 0; p--) add_pkt(k, $urandom_range(1, 5), '0, 1'b1);
      build_expect();
      run(2000, 1'b1, 1'b1, 0, to);
      n_checks++; if (to) $display("FAIL rand%0d_timeout got 1 exp 0", r); else n_pass++;
      n_checks++; if (fwd_q.size() !== exp_fwd_q.size()) $display("FAIL rand%0d_nbeats got %0d exp %0d", r, fwd_q.size(), exp_fwd_q.size()); else n_pass++;
      for (int i = 0; i < fwd_q.size() && i < exp_fwd_q.size(); i++) begin
        n_checks++;
        if (fwd_q[i] !== exp_fwd_q[i]) $display("FAIL rand%0d_beat%0d got %h/%b/%0d exp %h/%b/%0d", r, i, fwd_q[i].data, fwd_q[i].last, fwd_q[i].gid, exp_fwd_q[i].data, exp_fwd_q[i].last, exp_fwd_q[i].gid); else n_pass++;
      end
      n_checks++; if (done_q.size() !== exp_done_q.size()) $display("FAIL rand%0d_npkts got %0d exp %0d", r, done_q.size(), exp_done_q.size()); else n_pass++;
      for (int i = 0; i < done_q.size() && i < exp_done_q.size(); i++) begin
        n_checks++;
        if (done_q[i] !== exp_done_q[i]) $display("FAIL rand%0d_pkt%0d got len %0d id %0d exp len %0d id %0d", r, i, done_q[i].len, done_q[i].gid, exp_done_q[i].len, exp_done_q[i].gid); else n_pass++;
      end
    end
  endtask

  initial begin
    rst = 1'b1; tvalid_s = '0; tdata_s = '0; tlast_s = '0; tready_m = 1'b0;
    for (int k = 0; k < NR; k++) gap_force[k] = 0;
    @(posedge clk); #1;
    test_reset();
    test_single();
    test_contention();
    test_fairness();
    test_backpressure();
    test_gap();
    test_saturation();
    test_reset_mid();
    test_random();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
